// File: rtl/window_adrs_gen.sv
// Convolution window address generator: streams the feature-map address of every
// element of every KxK window (row-major), stride 1/2, with valid/ready handshake.
module window_adrs_gen #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DIM_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              filter_i,
    input  logic              stride_i,
    input  logic [DIM_W-1:0]  img_w_i,
    input  logic [DIM_W-1:0]  img_h_i,
    input  logic [ADDR_W-1:0] base_adrs_i,
    input  logic              ready_i,
    output logic [ADDR_W-1:0] adrs_o,
    output logic              valid_o,
    output logic              win_last_o,
    output logic              busy_o,
    output logic              ack_o
);

    localparam int unsigned CW = DIM_W + 2;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    state_e              state_q, state_d;
    logic                filter_q, filter_d;
    logic                stride_q, stride_d;
    logic [DIM_W-1:0]    img_w_q, img_w_d;
    logic [DIM_W-1:0]    img_h_q, img_h_d;
    logic [ADDR_W-1:0]   row_step_q, row_step_d;
    logic [DIM_W-1:0]    orow_q, orow_d, ocol_q, ocol_d;
    logic [DIM_W-1:0]    krow_q, krow_d, kcol_q, kcol_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic [ADDR_W-1:0]   win_base_q, win_base_d;
    logic [ADDR_W-1:0]   elem_row_q, elem_row_d;
    logic [ADDR_W-1:0]   adrs_q, adrs_d;
    logic                valid_q, valid_d;
    logic                win_last_q, win_last_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;

    logic [CW-1:0]       k_in, k_cfg, s_cfg, col_pos, row_pos;
    logic [DIM_W-1:0]    kmax;
    logic                col_more, row_more;
    logic [ADDR_W-1:0]   next_elem, next_win, next_row;

    // Window geometry; sums carry two extra bits so pos+S+K never overflows.
    assign k_in     = filter_i ? CW'(5) : CW'(3);
    assign k_cfg    = filter_q ? CW'(5) : CW'(3);
    assign s_cfg    = stride_q ? CW'(2) : CW'(1);
    assign kmax     = filter_q ? DIM_W'(4) : DIM_W'(2);
    assign col_pos  = stride_q ? (CW'(ocol_q) << 1) : CW'(ocol_q);
    assign row_pos  = stride_q ? (CW'(orow_q) << 1) : CW'(orow_q);
    assign col_more = (col_pos + s_cfg + k_cfg) <= CW'(img_w_q);
    assign row_more = (row_pos + s_cfg + k_cfg) <= CW'(img_h_q);

    assign next_elem = elem_row_q + ADDR_W'(img_w_q);
    assign next_win  = win_base_q + ADDR_W'(s_cfg);
    assign next_row  = row_base_q + row_step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        filter_d   = filter_q;
        stride_d   = stride_q;
        img_w_d    = img_w_q;
        img_h_d    = img_h_q;
        row_step_d = row_step_q;
        orow_d     = orow_q;
        ocol_d     = ocol_q;
        krow_d     = krow_q;
        kcol_d     = kcol_q;
        row_base_d = row_base_q;
        win_base_d = win_base_q;
        elem_row_d = elem_row_q;
        adrs_d     = adrs_q;
        valid_d    = valid_q;
        win_last_d = win_last_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d    = 1'b0;
                win_last_d = 1'b0;
                busy_d     = 1'b0;
                if (start_i) begin
                    filter_d   = filter_i;
                    stride_d   = stride_i;
                    img_w_d    = img_w_i;
                    img_h_d    = img_h_i;
                    row_step_d = stride_i ? (ADDR_W'(img_w_i) << 1) : ADDR_W'(img_w_i);
                    orow_d     = '0;
                    ocol_d     = '0;
                    krow_d     = '0;
                    kcol_d     = '0;
                    row_base_d = base_adrs_i;
                    win_base_d = base_adrs_i;
                    elem_row_d = base_adrs_i;
                    adrs_d     = base_adrs_i;
                    busy_d     = 1'b1;
                    if ((CW'(img_w_i) < k_in) || (CW'(img_h_i) < k_in)) begin
                        state_d = DONE;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        valid_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // Advance only on an accepted transfer; otherwise everything holds.
                if (valid_q && ready_i) begin
                    if (kcol_q != kmax) begin
                        kcol_d     = kcol_q + DIM_W'(1);
                        adrs_d     = adrs_q + ADDR_W'(1);
                        win_last_d = (krow_q == kmax) && (kcol_q == kmax - DIM_W'(1));
                    end else if (krow_q != kmax) begin
                        kcol_d     = '0;
                        krow_d     = krow_q + DIM_W'(1);
                        elem_row_d = next_elem;
                        adrs_d     = next_elem;
                        win_last_d = 1'b0;
                    end else if (col_more) begin
                        kcol_d     = '0;
                        krow_d     = '0;
                        ocol_d     = ocol_q + DIM_W'(1);
                        win_base_d = next_win;
                        elem_row_d = next_win;
                        adrs_d     = next_win;
                        win_last_d = 1'b0;
                    end else if (row_more) begin
                        kcol_d     = '0;
                        krow_d     = '0;
                        ocol_d     = '0;
                        orow_d     = orow_q + DIM_W'(1);
                        row_base_d = next_row;
                        win_base_d = next_row;
                        elem_row_d = next_row;
                        adrs_d     = next_row;
                        win_last_d = 1'b0;
                    end else begin
                        state_d    = DONE;
                        valid_d    = 1'b0;
                        win_last_d = 1'b0;
                        ack_d      = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                valid_d    = 1'b0;
                win_last_d = 1'b0;
                busy_d     = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filter_q   <= 1'b0;
            stride_q   <= 1'b0;
            img_w_q    <= '0;
            img_h_q    <= '0;
            row_step_q <= '0;
            orow_q     <= '0;
            ocol_q     <= '0;
            krow_q     <= '0;
            kcol_q     <= '0;
            row_base_q <= '0;
            win_base_q <= '0;
            elem_row_q <= '0;
            adrs_q     <= '0;
            valid_q    <= 1'b0;
            win_last_q <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            filter_q   <= filter_d;
            stride_q   <= stride_d;
            img_w_q    <= img_w_d;
            img_h_q    <= img_h_d;
            row_step_q <= row_step_d;
            orow_q     <= orow_d;
            ocol_q     <= ocol_d;
            krow_q     <= krow_d;
            kcol_q     <= kcol_d;
            row_base_q <= row_base_d;
            win_base_q <= win_base_d;
            elem_row_q <= elem_row_d;
            adrs_q     <= adrs_d;
            valid_q    <= valid_d;
            win_last_q <= win_last_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
        end
    end

    assign adrs_o     = adrs_q;
    assign valid_o    = valid_q;
    assign win_last_o = win_last_q;
    assign busy_o     = busy_q;
    assign ack_o      = ack_q;

endmodule
